// File: rtl/ff_arb_ctrl_pkg.sv
// Shared encodings and the bank update function for ff_bank_arb_ctrl.
package ff_arb_ctrl_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_TGL  = 2'b10;
  localparam logic [1:0] CMD_SET  = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_APPLY = 1'b1;

  // Widest bank the update function handles; callers zero-extend and slice.
  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] apply_cmd(input logic [1:0]       cmd,
                                                 input logic [MAX_W-1:0] mask,
                                                 input logic [MAX_W-1:0] val);
    logic [MAX_W-1:0] res;
    unique case (cmd)
      CMD_HOLD: res = val;
      CMD_CLR:  res = val & ~mask;
      CMD_TGL:  res = val ^ mask;
      CMD_SET:  res = val | mask;
      default:  res = val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr_i, or fixed priority
// when FF_ARB_CTRL_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

`ifdef FF_ARB_CTRL_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'(k);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  // Search starts at the pointer and wraps around once.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ff_bank_arb_ctrl.sv
// Arbitrates N requesters onto one W-bit hold/clear/toggle/set flip-flop bank.
// Define FF_ARB_CTRL_FIXED_PRIO_EN for fixed lowest-index priority.
module ff_bank_arb_ctrl
  import ff_arb_ctrl_pkg::*;
#(
  parameter int unsigned N     = 4,  // 2..8
  parameter int unsigned W     = 4,  // at most MAX_W
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N-1:0]     REQ,
  input  logic [2*N-1:0]   CMD,
  input  logic [W*N-1:0]   MASK,
  output logic [N-1:0]     GNT,
  output logic [W-1:0]     Q,
  output logic             BUSY,
  output logic [CNT_W-1:0] OP_CNT
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [0:0]       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [W-1:0]     q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [W-1:0]     mask_q, mask_d;

  logic [N-1:0]     arb_gnt;
  logic [PTR_W-1:0] ptr;
  logic [1:0]       cmd_sel;
  logic [W-1:0]     mask_sel;
  logic [MAX_W-1:0] mask_ext, q_in_ext, q_ext;
  logic             unused_q_ext;

  rr_arbiter #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i (REQ),
    .ptr_i (ptr),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    cmd_sel  = CMD_HOLD;
    mask_sel = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (arb_gnt[i]) begin
        cmd_sel  = CMD[2*i +: 2];
        mask_sel = MASK[W*i +: W];
      end
    end
  end

  always_comb begin
    mask_ext           = '0;
    mask_ext[W-1:0]    = mask_q;
    q_in_ext           = '0;
    q_in_ext[W-1:0]    = q_q;
    q_ext              = apply_cmd(cmd_q, mask_ext, q_in_ext);
  end

  // Bits above W are always zero-extended padding.
  assign unused_q_ext = ^q_ext;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    mask_d  = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          state_d = ST_APPLY;
          gnt_d   = arb_gnt;
          cmd_d   = cmd_sel;
          mask_d  = mask_sel;
        end else begin
          gnt_d = '0;
        end
      end
      ST_APPLY: begin
        q_d     = q_ext[W-1:0];
        cnt_d   = cnt_q + CNT_W'(1);
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      cmd_q   <= CMD_HOLD;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      mask_q  <= mask_d;
    end
  end

`ifdef FF_ARB_CTRL_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Pointer advances past the winner as the operation completes.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_APPLY) begin
      for (int i = 0; i < int'(N); i++) begin
        if (gnt_q[i]) begin
          ptr_d = (i == int'(N) - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`endif

  assign GNT    = gnt_q;
  assign Q      = q_q;
  assign BUSY   = (state_q == ST_APPLY);
  assign OP_CNT = cnt_q;

endmodule

// File: tb/tb_ff_bank_arb_ctrl.sv
// Self-checking bench for ff_bank_arb_ctrl: vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_ff_bank_arb_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CW    = 2 * N;
  localparam int unsigned MW    = W * N;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [N-1:0]     REQ = '0;
  logic [CW-1:0]    CMD = '0;
  logic [MW-1:0]    MASK = '0;
  logic [N-1:0]     GNT;
  logic [W-1:0]     Q;
  logic             BUSY;
  logic [CNT_W-1:0] OP_CNT;

  ff_bank_arb_ctrl #(
    .N     (N),
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .REQ    (REQ),
    .CMD    (CMD),
    .MASK   (MASK),
    .GNT    (GNT),
    .Q      (Q),
    .BUSY   (BUSY),
    .OP_CNT (OP_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic             do_rst;
    logic [N-1:0]     req;
    logic [CW-1:0]    cmd;
    logic [MW-1:0]    mask;
    logic [N-1:0]     gnt;
    logic [W-1:0]     q;
    logic             busy;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic do_rst, input logic [N-1:0] req, input logic [CW-1:0] cmd,
                     input logic [MW-1:0] mask, input logic [N-1:0] gnt, input logic [W-1:0] q,
                     input logic busy, input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.do_rst = do_rst; v.req = req; v.cmd = cmd; v.mask = mask;
    v.gnt = gnt; v.q = q; v.busy = busy; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic check(input string tag, input logic [N-1:0] eg, input logic [W-1:0] eq,
                       input logic eb, input logic [CNT_W-1:0] ec);
    n_cmp++;
    if (GNT !== eg) begin
      n_fail++;
      $display("FAIL %s GNT: got %b expected %b", tag, GNT, eg);
    end
    n_cmp++;
    if (Q !== eq) begin
      n_fail++;
      $display("FAIL %s Q: got %b expected %b", tag, Q, eq);
    end
    n_cmp++;
    if (BUSY !== eb) begin
      n_fail++;
      $display("FAIL %s BUSY: got %b expected %b", tag, BUSY, eb);
    end
    n_cmp++;
    if (OP_CNT !== ec) begin
      n_fail++;
      $display("FAIL %s OP_CNT: got %0d expected %0d", tag, OP_CNT, ec);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: at most one operation pending, resolved on the next edge.
  logic [W-1:0] m_q;
  int           m_cnt;
  int           m_ptr;
  int           m_pend;
  logic [1:0]   m_cmd;
  logic [W-1:0] m_mask;

  task automatic model_reset();
    m_q = '0; m_cnt = 0; m_ptr = 0; m_pend = -1; m_cmd = '0; m_mask = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] req, input logic [CW-1:0] cmd,
                            input logic [MW-1:0] mask);
    int w;
    if (m_pend >= 0) begin
      for (int b = 0; b < int'(W); b++) begin
        if (m_mask[b]) begin
          case (m_cmd)
            2'd1: m_q[b] = 1'b0;
            2'd2: m_q[b] = ~m_q[b];
            2'd3: m_q[b] = 1'b1;
            default: ;
          endcase
        end
      end
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
`ifndef FF_ARB_CTRL_FIXED_PRIO_EN
      m_ptr = (m_pend + 1) % int'(N);
`endif
      m_pend = -1;
    end else if (req != '0) begin
      w = -1;
      for (int k = 0; k < int'(N); k++) begin
        if (w < 0 && req[(m_ptr + k) % int'(N)]) w = (m_ptr + k) % int'(N);
      end
      m_pend = w;
      m_cmd  = cmd[2*w +: 2];
      m_mask = mask[W*w +: W];
    end
  endtask

  task automatic model_check(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_pend >= 0) eg[m_pend] = 1'b1;
    check(tag, eg, m_q, m_pend >= 0, CNT_W'(m_cnt));
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
    model_reset();
  endtask

  initial begin
    // Power-on reset
    step();
    step();
    check("reset", '0, '0, 1'b0, '0);
    RST_N = 1'b1;

`ifndef FF_ARB_CTRL_FIXED_PRIO_EN
    // Single request, round-robin order, set/clear/hold, late CMD change,
    // and a request arriving during APPLY.
    add(0, 4'b0001, 8'hAA, 16'h0005, 4'b0001, 4'h0, 1, 8'd0);
    add(0, 4'b0000, 8'hAA, 16'h0005, 4'b0000, 4'h5, 0, 8'd1);
    add(0, 4'b0000, 8'hAA, 16'h0005, 4'b0000, 4'h5, 0, 8'd1);
    add(1, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'h0, 0, 8'd0);
    add(0, 4'b1111, 8'hAA, 16'h1111, 4'b0001, 4'h0, 1, 8'd0);
    add(0, 4'b1111, 8'hAA, 16'h1111, 4'b0000, 4'h1, 0, 8'd1);
    add(0, 4'b1111, 8'hAA, 16'h1111, 4'b0010, 4'h1, 1, 8'd1);
    add(0, 4'b1111, 8'hAA, 16'h1111, 4'b0000, 4'h0, 0, 8'd2);
    add(0, 4'b1111, 8'hAA, 16'h1111, 4'b0100, 4'h0, 1, 8'd2);
    add(0, 4'b1111, 8'hAA, 16'h1111, 4'b0000, 4'h1, 0, 8'd3);
    add(0, 4'b1111, 8'hAA, 16'h1111, 4'b1000, 4'h1, 1, 8'd3);
    add(0, 4'b1111, 8'hAA, 16'h1111, 4'b0000, 4'h0, 0, 8'd4);
    add(0, 4'b1111, 8'hAA, 16'h1111, 4'b0001, 4'h0, 1, 8'd4);
    add(0, 4'b0000, 8'hAA, 16'h1111, 4'b0000, 4'h1, 0, 8'd5);
    add(0, 4'b0100, 8'h30, 16'h0A00, 4'b0100, 4'h1, 1, 8'd5);
    add(0, 4'b0000, 8'h30, 16'h0A00, 4'b0000, 4'hB, 0, 8'd6);
    add(0, 4'b1000, 8'h40, 16'h3000, 4'b1000, 4'hB, 1, 8'd6);
    add(0, 4'b0000, 8'h40, 16'h3000, 4'b0000, 4'h8, 0, 8'd7);
    add(0, 4'b0010, 8'h00, 16'h0000, 4'b0010, 4'h8, 1, 8'd7);
    add(0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'h8, 0, 8'd8);
    add(0, 4'b0001, 8'h03, 16'h0001, 4'b0001, 4'h8, 1, 8'd8);
    add(0, 4'b0000, 8'h01, 16'hFFFF, 4'b0000, 4'h9, 0, 8'd9);
    add(0, 4'b0001, 8'h02, 16'h0002, 4'b0001, 4'h9, 1, 8'd9);
    add(0, 4'b0100, 8'h22, 16'h0402, 4'b0000, 4'hB, 0, 8'd10);
    add(0, 4'b0100, 8'h22, 16'h0402, 4'b0100, 4'hB, 1, 8'd10);
    add(0, 4'b0000, 8'h22, 16'h0402, 4'b0000, 4'hF, 0, 8'd11);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) begin
        RST_N = 1'b0;
        #1;
        check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].q, tbl[i].busy, tbl[i].cnt);
        #1;
        RST_N = 1'b1;
      end else begin
        REQ = tbl[i].req; CMD = tbl[i].cmd; MASK = tbl[i].mask;
        step();
        check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].q, tbl[i].busy, tbl[i].cnt);
      end
    end
`else
    // Fixed priority: REQ[1] always beats REQ[3].
    do_reset();
    REQ = 4'b1010; CMD = '0; MASK = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("prio%0d", k), (k % 2 == 0) ? 4'b0010 : 4'b0000, 4'h0,
            k % 2 == 0, CNT_W'((k + 1) / 2));
    end
    REQ = '0;
    step();
`endif

    // Reset during APPLY discards the pending set.
    do_reset();
    REQ = 4'b0001; CMD = 8'h03; MASK = 16'h000F;
    step();
    check("abort_apply", 4'b0001, 4'h0, 1'b1, 8'd0);
    REQ = '0;
    RST_N = 1'b0;
    #1;
    check("abort_async", 4'b0000, 4'h0, 1'b0, 8'd0);
    step();
    check("abort_held", 4'b0000, 4'h0, 1'b0, 8'd0);
    RST_N = 1'b1;
    step();
    check("abort_after", 4'b0000, 4'h0, 1'b0, 8'd0);

    // Counter wrap: one set then 255 back-to-back holds.
    do_reset();
    REQ = 4'b0001; CMD = 8'h03; MASK = 16'h0006;
    step();
    REQ = '0;
    step();
    check("wrap_set", 4'b0000, 4'h6, 1'b0, 8'd1);
    REQ = 4'b0001; CMD = 8'h00; MASK = 16'h000F;
    for (int k = 0; k < 2 * 254; k++) step();
    check("wrap_255", 4'b0000, 4'h6, 1'b0, 8'd255);
    step();
    step();
    check("wrap_0", 4'b0000, 4'h6, 1'b0, 8'd0);
    REQ = '0;
    step();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      REQ  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      CMD  = CW'($urandom);
      MASK = MW'($urandom);
      @(posedge CLK);
      model_edge(REQ, CMD, MASK);
      #1;
      model_check($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
